// File: rtl/seg7_ctrl.sv
// Register-programmable seven-segment display controller that time-shares the display between a software DATA register and a debug source.
// Optional build macro SEG7_CTRL_DBG_LIVE_EN: when defined, dbg_q tracks dbg_data every cycle.
module seg7_ctrl #(
   parameter int nr_digit = 8,
   parameter int period_w = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reg_wen,
   input  logic [1:0]            reg_addr,
   input  logic [31:0]           reg_wdata,
   input  logic                  reg_ren,
   output logic [31:0]           reg_rdata,
   output logic                  reg_rvalid,
   input  logic [4*nr_digit-1:0] dbg_data,
   input  logic                  dbg_valid,
   output logic [4*nr_digit-1:0] disp_data,
   output logic                  disp_src
);

   localparam int dw = 4 * nr_digit;

   typedef enum logic {
      SHOW_SW  = 1'b0,
      SHOW_DBG = 1'b1
   } state_t;

   state_t              state;
   logic [dw-1:0]       data_q;
   logic [dw-1:0]       dbg_q;
   logic [1:0]          mode_q;
   logic [period_w-1:0] period_q;
   logic [period_w-1:0] cnt;
   logic                dbg_seen;

   logic                ctrl_wr;
   logic                period_wr;
   logic                status_wr;
   logic [1:0]          mode_eff;
   logic                unused_wdata;

   assign ctrl_wr   = reg_wen && (reg_addr == 2'd1);
   assign period_wr = reg_wen && (reg_addr == 2'd2);
   assign status_wr = reg_wen && (reg_addr == 2'd3);

   // A CTRL write steers the FSM on the same edge the register loads.
   assign mode_eff     = ctrl_wr ? reg_wdata[1:0] : mode_q;
   assign unused_wdata = ^reg_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q   <= '0;
         mode_q   <= '0;
         period_q <= '0;
         dbg_q    <= '0;
         dbg_seen <= 1'b0;
      end else begin
         if (reg_wen) begin
            case (reg_addr)
               2'd0:    data_q   <= reg_wdata[dw-1:0];
               2'd1:    mode_q   <= reg_wdata[1:0];
               2'd2:    period_q <= period_w'(reg_wdata);
               default: ;
            endcase
         end
         // A new capture outranks a coincident clear.
         if (dbg_valid)
            dbg_seen <= 1'b1;
         else if (status_wr)
            dbg_seen <= 1'b0;
`ifdef SEG7_CTRL_DBG_LIVE_EN
         dbg_q <= dbg_data;
`else
         if (dbg_valid)
            dbg_q <= dbg_data;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SHOW_SW;
         cnt   <= '0;
      end else begin
         case (mode_eff)
            2'd1: begin
               state <= SHOW_DBG;
               cnt   <= '0;
            end
            2'd2: begin
               // Register writes restart the dwell in whatever state is current.
               if (ctrl_wr || period_wr) begin
                  cnt <= '0;
               end else if (period_q != '0) begin
                  if (cnt == period_q - period_w'(1)) begin
                     state <= (state == SHOW_SW) ? SHOW_DBG : SHOW_SW;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + period_w'(1);
                  end
               end
            end
            default: begin
               state <= SHOW_SW;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         disp_data <= '0;
         disp_src  <= 1'b0;
      end else begin
         disp_data <= (state == SHOW_DBG) ? dbg_q : data_q;
         disp_src  <= (state == SHOW_DBG);
      end
   end

   // Reads sample the registers before any same-cycle write lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_rvalid <= 1'b0;
         reg_rdata  <= '0;
      end else begin
         reg_rvalid <= reg_ren;
         if (reg_ren) begin
            case (reg_addr)
               2'd0:    reg_rdata <= 32'(data_q);
               2'd1:    reg_rdata <= {30'd0, mode_q};
               2'd2:    reg_rdata <= 32'(period_q);
               default: reg_rdata <= {30'd0, dbg_seen, disp_src};
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seg7_ctrl.sv
// Directed bench for seg7_ctrl: read responses are checked against a queue of expected values.
module tb_seg7_ctrl;

   logic        clk;
   logic        rst;
   logic        reg_wen;
   logic [1:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_ren;
   logic [31:0] reg_rdata;
   logic        reg_rvalid;
   logic [31:0] dbg_data;
   logic        dbg_valid;
   logic [31:0] disp_data;
   logic        disp_src;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];

   seg7_ctrl #(.nr_digit(8), .period_w(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .reg_wen    (reg_wen),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_ren    (reg_ren),
      .reg_rdata  (reg_rdata),
      .reg_rvalid (reg_rvalid),
      .dbg_data   (dbg_data),
      .dbg_valid  (dbg_valid),
      .disp_data  (disp_data),
      .disp_src   (disp_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
      reg_wen   = 1'b1;
      reg_addr  = addr;
      reg_wdata = data;
      @(negedge clk);
      reg_wen   = 1'b0;
   endtask

   task automatic readReg(input logic [1:0] addr, input logic [31:0] expected);
      reg_ren  = 1'b1;
      reg_addr = addr;
      exp_q.push_back(expected);
      @(negedge clk);
      reg_ren  = 1'b0;
   endtask

   task automatic pulseDbg(input logic [31:0] value);
      dbg_data  = value;
      dbg_valid = 1'b1;
      @(negedge clk);
      dbg_valid = 1'b0;
   endtask

   // Every read response is scored against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reg_rvalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL rd_unexpected observed=%h expected=none", reg_rdata);
         end else begin
            checkOutput("rd_data", reg_rdata, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] want;
      rst = 1'b1; reg_wen = 1'b0; reg_addr = 2'd0; reg_wdata = '0;
      reg_ren = 1'b0; dbg_data = '0; dbg_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_disp_data", disp_data, 32'h0);
      checkOutput("rst_disp_src", 32'(disp_src), 32'h0);
      checkOutput("rst_rvalid", 32'(reg_rvalid), 32'h0);
      checkOutput("rst_rdata", reg_rdata, 32'h0);

      applyStimulus(2'd0, 32'h1234ABCD);
      checkOutput("data_n1", disp_data, 32'h0);
      @(negedge clk);
      checkOutput("data_n2", disp_data, 32'h1234ABCD);
      checkOutput("data_src", 32'(disp_src), 32'h0);
      readReg(2'd0, 32'h1234ABCD);
      @(negedge clk);
      checkOutput("rdata_hold", reg_rdata, 32'h1234ABCD);

      pulseDbg(32'hDEADBEEF);
      applyStimulus(2'd1, 32'h1);
      checkOutput("dbg_src_n1", 32'(disp_src), 32'h0);
      @(negedge clk);
      checkOutput("dbg_src_n2", 32'(disp_src), 32'h1);
      checkOutput("dbg_data_n2", disp_data, 32'hDEADBEEF);
      readReg(2'd3, 32'h3);
      applyStimulus(2'd3, 32'h0);
      readReg(2'd3, 32'h1);
      readReg(2'd1, 32'h1);

      applyStimulus(2'd0, 32'h11111111);
      pulseDbg(32'h22222222);
      applyStimulus(2'd2, 32'h4);
      applyStimulus(2'd1, 32'h2);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         want = (k <= 4 || k > 8) ? 32'h1 : 32'h0;
         checkOutput("alt4_src", 32'(disp_src), want);
         checkOutput("alt4_data", disp_data, want[0] ? 32'h22222222 : 32'h11111111);
      end
      applyStimulus(2'd2, 32'h0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checkOutput("alt0_hold_src", 32'(disp_src), 32'h0);
         checkOutput("alt0_hold_data", disp_data, 32'h11111111);
      end

      applyStimulus(2'd2, 32'h1);
      @(negedge clk);
      for (int k = 2; k <= 7; k++) begin
         @(negedge clk);
         checkOutput("alt1_src", 32'(disp_src), (k % 2 == 0) ? 32'h1 : 32'h0);
      end
      applyStimulus(2'd2, 32'h3);
      checkOutput("alt3_src_g0", 32'(disp_src), 32'h1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         want = (k <= 3 || k == 7) ? 32'h1 : 32'h0;
         checkOutput("alt3_src", 32'(disp_src), want);
      end

      applyStimulus(2'd1, 32'h0);
      applyStimulus(2'd0, 32'h5);
      reg_wen = 1'b1; reg_ren = 1'b1; reg_addr = 2'd0; reg_wdata = 32'h9;
      exp_q.push_back(32'h5);
      @(negedge clk);
      reg_wen = 1'b0; reg_ren = 1'b0;
      readReg(2'd0, 32'h9);
      applyStimulus(2'd1, 32'h1);
      @(negedge clk);
      checkOutput("mode1_src", 32'(disp_src), 32'h1);
      applyStimulus(2'd1, 32'h3);
      @(negedge clk);
      checkOutput("mode3_src", 32'(disp_src), 32'h0);
      checkOutput("mode3_data", disp_data, 32'h9);
      readReg(2'd1, 32'h3);

      applyStimulus(2'd2, 32'h2);
      applyStimulus(2'd1, 32'h2);
      repeat (3) @(negedge clk);
      rst = 1'b1; reg_ren = 1'b1; reg_addr = 2'd0;
      @(negedge clk);
      rst = 1'b0; reg_ren = 1'b0;
      checkOutput("midrst_disp_data", disp_data, 32'h0);
      checkOutput("midrst_disp_src", 32'(disp_src), 32'h0);
      checkOutput("midrst_rvalid", 32'(reg_rvalid), 32'h0);
      checkOutput("midrst_rdata", reg_rdata, 32'h0);
      readReg(2'd1, 32'h0);
      readReg(2'd2, 32'h0);
      readReg(2'd3, 32'h0);

      pulseDbg(32'hCAFE0001);
      applyStimulus(2'd1, 32'h1);
      dbg_data = 32'h0BADF00D;
      @(negedge clk);
      @(negedge clk);
`ifdef SEG7_CTRL_DBG_LIVE_EN
      checkOutput("live_dbg_data", disp_data, 32'h0BADF00D);
`else
      checkOutput("held_dbg_data", disp_data, 32'hCAFE0001);
`endif

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $error("[TB] FAIL rd_timeout observed=%0d_pending expected=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
